sram_axi_arbiter: RTL
=====================

// Module: sram_axi_arbiter
// PURPOSE
//  Shares one AXI3/4 master port between the fetch stage (instruction read) and the mem stage (data read/write).
//  Both requesters use the sram-like handshake: req/addr_ok accepts a request, data_ok completes it.
//  One transaction is outstanding at a time; requesters stall on addr_ok/data_ok.
//  Sits between the CPU core and the SoC AXI crossbar.
// PARAMETERS
//  INST_ID  4'd0  AXI arid for instruction reads
//  DATA_ID  4'd1  AXI arid/awid for data accesses
// PORTS
//  clk           in   1   core clock, all state on posedge
//  resetn        in   1   asynchronous, active-low reset
//  inst_req      in   1   fetch read request (always word)
//  inst_addr     in   32  fetch byte address
//  inst_addr_ok  out  1   inst request accepted this cycle
//  inst_data_ok  out  1   inst_rdata valid, 1-cycle pulse
//  inst_rdata    out  32  instruction word
//  data_req      in   1   data request
//  data_wr       in   1   1=write, 0=read
//  data_size     in   2   0=byte, 1=half, 2=word
//  data_addr     in   32  data byte address
//  data_wdata    in   32  write data, lane-aligned
//  data_addr_ok  out  1   data request accepted this cycle
//  data_data_ok  out  1   read data valid / write done, 1-cycle pulse
//  data_rdata    out  32  read data
//  arid/araddr/arsize/arvalid  out 4/32/3/1; arready in 1  AXI AR channel
//  rid/rdata/rvalid  in 4/32/1; rready out 1  AXI R channel
//  awid/awaddr/awsize/awvalid  out 4/32/3/1; awready in 1  AXI AW channel
//  wdata/wstrb/wvalid  out 32/4/1; wready in 1  AXI W channel
//  bvalid  in 1; bready out 1  AXI B channel
// BEHAVIOUR
//  - Tie-offs: len=0, burst=INCR, lock/cache/prot=0, wlast=1; wid=DATA_ID. Ignore rresp/bresp/rlast.
//  - FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B. Reset enters IDLE.
//    All valids, x_addr_ok, x_data_ok, rready and bready reset to 0; rdata regs reset to 0.
//  - IDLE: grant is combinational; x_addr_ok = grant & x_req. Fixed priority: data over inst.
//    On the accept cycle, latch id, addr, size, wr and wdata. Read -> RD_AR; write -> WR_AWW.
//  - RD_AR: arvalid=1 and held stable until arready. Then go to RD_R.
//  - RD_R: rready=1. On rvalid, latch rdata into the requester selected by the latched id.
//    Pulse that requester's data_ok the next cycle and return to IDLE; no new grant in that cycle.
//  - WR_AWW: awvalid and wvalid are raised together. Each drops independently on its ready, tracked by aw_done/w_done.
//    When both are done, go to WR_B.
//  - WR_B: bready=1. On bvalid, pulse data_data_ok the next cycle and return to IDLE.
//  - Minimum latency: accept at N, arvalid at N+1; with arready/rvalid back-to-back, data_ok at N+4.
//  - Size/address rules:
//    arsize/awsize = {1'b0,size}; inst size is 2; size 2'b11 is treated as word.
//    wstrb: byte=4'b0001<<addr[1:0], half=4'b0011<<addr[1:0], word=4'b1111.
//    addr is passed unmodified; alignment is the core's duty.
//  - Simultaneous inst_req & data_req in IDLE: only data_addr_ok asserts; inst stays pending.
//  - Requests arriving outside IDLE: addr_ok stays 0; the requester must hold req.
//  - rid/bid are not checked; the single outstanding transaction identifies the owner.
//  - Reset mid-transaction: immediate return to IDLE; the outstanding transfer is abandoned and no data_ok is issued.
// CONFIGURATION
//  SRAM_AXI_ARB_RR_EN defined: round-robin grant. A last_grant flop prefers the requester not served last
//    when both request in IDLE; it resets to "inst served", so data wins the first tie.
//  Not defined: fixed data-over-inst priority as above.
// STRUCTURE
//  cpu_axi_pkg: FSM state enum, INST_ID/DATA_ID defaults, AXI tie-off constants, size->strb function.
//  One sub-module, sram_axi_wstrb_gen (size+addr[1:0] -> wstrb). All else is flat.
// TESTING
//  1 inst_req addr=bfc00000 alone; arready/rvalid immediate, rdata=3c1d0000
//    -> inst_addr_ok at N, arvalid N+1, inst_data_ok N+4 with inst_rdata=3c1d0000.
//  2 inst_req and data_req (rd, 1fc00010) in the same cycle -> data granted first.
//    inst_addr_ok only after data_data_ok; in RR mode the next tie goes to inst.
//  3 data sb size=0 addr=..03 wdata=AB000000; awready 3 cycles after wready
//    -> wstrb=1000, awsize=0, single data_data_ok after bvalid.
//  4 arready held low 5 cycles -> araddr/arvalid stable throughout; inst_addr_ok stays 0 meanwhile.
//  5 resetn low during RD_R -> all valids 0 asynchronously; no data_ok; IDLE after release.
//  6 sh size=1 addr=..02 -> wstrb=1100; sw -> 1111, awsize=2.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the sram-like to AXI bridge/arbiter.
// Contents: FSM state encodings, default AXI IDs, AXI tie-off constants,
// the latched request payload struct, and size/strobe helper functions.
package cpu_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = 4;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_AR  = 3'd1;
  localparam logic [2:0] ST_RD_R   = 3'd2;
  localparam logic [2:0] ST_WR_AWW = 3'd3;
  localparam logic [2:0] ST_WR_B   = 3'd4;

  // Default transaction IDs
  localparam logic [ID_W-1:0] INST_ID_DEF = 4'd0;
  localparam logic [ID_W-1:0] DATA_ID_DEF = 4'd1;

  // AXI tie-offs: single-beat INCR, normal, non-cacheable, unprivileged
  localparam logic [7:0] AXI_LEN        = 8'h00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_CACHE      = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b000;

  // Request captured on the accept cycle
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // sram size code -> AXI size; the unused code 2'b11 is treated as word
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return (size == 2'b11) ? 3'b010 : {1'b0, size};
  endfunction

  // AXI size + byte offset -> write strobe
  function automatic logic [STRB_W-1:0] size_to_strb(input logic [2:0] size,
                                                      input logic [1:0] off);
    case (size)
      3'd0:    return 4'b0001 << off;
      3'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_axi_wstrb_gen.sv
// Write-strobe generator.
// Ports: size (AXI size code), addr_lo (byte offset), wstrb (byte lanes).
module sram_axi_wstrb_gen
  import cpu_axi_pkg::*;
(
  input  logic [2:0]        size,
  input  logic [1:0]        addr_lo,
  output logic [STRB_W-1:0] wstrb
);

  assign wstrb = size_to_strb(size, addr_lo);

endmodule

// File: rtl/sram_axi_arbiter.sv
// Arbitrates the fetch (inst) and mem (data) sram-like ports onto one AXI
// master with a single outstanding transaction.
// Ports: clk/resetn; inst_* fetch port; data_* mem port; ar*/r*/aw*/w*/b*
// AXI master channels including constant tie-offs.
// Config: define SRAM_AXI_ARB_RR_EN for round-robin grant on ties;
// otherwise data has fixed priority over inst.
module sram_axi_arbiter
  import cpu_axi_pkg::*;
#(
  parameter logic [ID_W-1:0] INST_ID = INST_ID_DEF,
  parameter logic [ID_W-1:0] DATA_ID = DATA_ID_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  // fetch port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // mem port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // AR
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // R
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  // AW
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // W
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // B
  input  logic              bvalid,
  output logic              bready
);

  logic [2:0]        state_q, state_n;
  req_t              req_q, req_n;
  logic              arvalid_q, arvalid_n;
  logic              rready_q, rready_n;
  logic              awvalid_q, awvalid_n;
  logic              wvalid_q, wvalid_n;
  logic              bready_q, bready_n;
  logic              aw_done_q, aw_done_n;
  logic              w_done_q, w_done_n;
  logic              inst_data_ok_q, inst_data_ok_n;
  logic              data_data_ok_q, data_data_ok_n;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_n;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_n;
  logic              grant_en, grant_data, grant_inst;
  logic              aw_now, w_now;

  // The single outstanding transaction identifies its owner; rid is not needed
  logic unused_rid;
  assign unused_rid = ^rid;

  // No grant during the data_ok cycle that follows a completion
  assign grant_en = (state_q == ST_IDLE) & ~inst_data_ok_q & ~data_data_ok_q;

`ifdef SRAM_AXI_ARB_RR_EN
  // 1 = inst was served last; resets so that data wins the first tie
  logic last_inst_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              last_inst_q <= 1'b1;
    else if (grant_en && (data_req || inst_req)) last_inst_q <= ~grant_data;
  end

  assign grant_data = data_req & (~inst_req | last_inst_q);
`else
  assign grant_data = data_req;
`endif
  assign grant_inst = inst_req & ~grant_data;

  assign data_addr_ok = grant_en & grant_data;
  assign inst_addr_ok = grant_en & grant_inst;

  // Next-state and registered-output logic
  always_comb begin
    state_n        = state_q;
    req_n          = req_q;
    arvalid_n      = 1'b0;
    rready_n       = 1'b0;
    awvalid_n      = 1'b0;
    wvalid_n       = 1'b0;
    bready_n       = 1'b0;
    aw_done_n      = aw_done_q;
    w_done_n       = w_done_q;
    inst_data_ok_n = 1'b0;
    data_data_ok_n = 1'b0;
    inst_rdata_n   = inst_rdata_q;
    data_rdata_n   = data_rdata_q;
    aw_now         = 1'b0;
    w_now          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_addr_ok) begin
          req_n = '{id: DATA_ID, addr: data_addr, size: axi_size(data_size),
                    wr: data_wr, wdata: data_wdata};
          if (data_wr) begin
            state_n   = ST_WR_AWW;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
          end else begin
            state_n   = ST_RD_AR;
            arvalid_n = 1'b1;
          end
        end else if (inst_addr_ok) begin
          req_n     = '{id: INST_ID, addr: inst_addr, size: 3'b010,
                        wr: 1'b0, wdata: '0};
          state_n   = ST_RD_AR;
          arvalid_n = 1'b1;
        end
      end

      ST_RD_AR: begin
        if (arready) state_n   = ST_RD_R;
        else         arvalid_n = 1'b1;
      end

      // rready is raised one cycle after entry and drops on the handshake
      ST_RD_R: begin
        if (rvalid && rready_q) begin
          state_n = ST_IDLE;
          if (req_q.id == INST_ID) begin
            inst_rdata_n   = rdata;
            inst_data_ok_n = 1'b1;
          end else begin
            data_rdata_n   = rdata;
            data_data_ok_n = 1'b1;
          end
        end else begin
          rready_n = 1'b1;
        end
      end

      // AW and W complete independently; leave once both have handshaken
      ST_WR_AWW: begin
        aw_now    = aw_done_q | (awvalid_q & awready);
        w_now     = w_done_q  | (wvalid_q & wready);
        aw_done_n = aw_now;
        w_done_n  = w_now;
        awvalid_n = ~aw_now;
        wvalid_n  = ~w_now;
        if (aw_now && w_now) state_n = ST_WR_B;
      end

      ST_WR_B: begin
        if (bvalid && bready_q) begin
          state_n        = ST_IDLE;
          data_data_ok_n = req_q.wr;
        end else begin
          bready_n = 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_n;
      req_q          <= req_n;
      arvalid_q      <= arvalid_n;
      rready_q       <= rready_n;
      awvalid_q      <= awvalid_n;
      wvalid_q       <= wvalid_n;
      bready_q       <= bready_n;
      aw_done_q      <= aw_done_n;
      w_done_q       <= w_done_n;
      inst_data_ok_q <= inst_data_ok_n;
      data_data_ok_q <= data_data_ok_n;
      inst_rdata_q   <= inst_rdata_n;
      data_rdata_q   <= data_rdata_n;
    end
  end

  sram_axi_wstrb_gen u_wstrb_gen (
    .size    (req_q.size),
    .addr_lo (req_q.addr[1:0]),
    .wstrb   (wstrb)
  );

  assign inst_data_ok = inst_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_data_ok = data_data_ok_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = req_q.id;
  assign araddr  = req_q.addr;
  assign arsize  = req_q.size;
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = req_q.id;
  assign awaddr  = req_q.addr;
  assign awsize  = req_q.size;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign awvalid = awvalid_q;

  assign wid     = DATA_ID;
  assign wdata   = req_q.wdata;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule
